dram_bank_ctrl: RTL and testbench

- Request/response front end that sits directly upstream of the DRAM bank (MACROS_NUM macros sharing one address, we and cme).
- Accepts one read, write or compute-mode (CM) request at a time over valid/ready.
- Drives the bank pins, captures q/cmOut after a fixed read latency, and returns the result over valid/ready.
- Interleaves a periodic refresh sweep: a read followed by a write-back of every row address.

---
 rtl/dram_ctrl_pkg.sv | 31 +++
 rtl/dram_refresh_timer.sv | 39 +++
 rtl/dram_bank_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared constants for the DRAM bank front end: opcodes, FSM state
// encoding, default widths and a saturating-increment helper.
package dram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH       = 8;
  localparam int DEF_DATA_WIDTH       = 512;
  localparam int DEF_READ_LAT         = 1;
  localparam int DEF_REFRESH_INTERVAL = 1024;

  // Request opcodes; the reserved code is serviced as a read.
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CM    = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  // FSM state encoding, exported on the debug port as-is.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ISSUE    = 3'd1;
  localparam state_t ST_WAIT     = 3'd2;
  localparam state_t ST_RESP     = 3'd3;
  localparam state_t ST_REF_RD   = 3'd4;
  localparam state_t ST_REF_WAIT = 3'd5;
  localparam state_t ST_REF_WR   = 3'd6;

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh scheduler: free-running interval counter, a sticky pending flag
// set at each wrap, and the row pointer for the next refresh. Pulsing
// advance marks the current row done (pointer steps, pending clears).
module dram_refresh_timer import dram_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] ref_ptr
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] cnt;

  // Interval counter, pending flag (wrap wins over a same-cycle clear,
  // extra wraps while pending are absorbed) and row pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
      ref_ptr <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        pending <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
        if (advance) pending <= 1'b0;
      end
      if (advance) ref_ptr <= ref_ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dram_bank_ctrl.sv
// Single-outstanding request/response front end for one DRAM bank, with an
// interleaved read/write-back refresh sweep over every row.
// Optional build macro DRAM_BANK_CTRL_PERF_EN adds saturating 32-bit
// operation counters (read, write, compute-mode, refresh).
//
// Handshakes: a transfer happens on any rising edge where valid and ready
// are both 1; a source holds valid and its payload stable until then, and
// ready never depends combinationally on valid.
module dram_bank_ctrl import dram_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int READ_LAT         = DEF_READ_LAT,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_cm,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic                  bank_we,
  output logic                  bank_cme,
  output logic [DATA_WIDTH-1:0] bank_d,
  output logic [DATA_WIDTH-1:0] bank_cmin,
  input  logic [DATA_WIDTH-1:0] bank_q,
  input  logic [DATA_WIDTH-1:0] bank_cmout,
  output logic [2:0]            dbg_state
`ifdef DRAM_BANK_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_cm_cnt,
  output logic [31:0]           perf_ref_cnt
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  state_t                state;
  logic [1:0]            cur_op;
  logic [2:0]            lat_cnt;
  logic                  armed;
  logic                  we_q;
  logic                  cme_q;
  logic                  ref_pending;
  logic [ADDR_WIDTH-1:0] ref_ptr;
  logic                  ref_advance;
  logic                  accept;

  dram_refresh_timer #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .advance (ref_advance),
    .pending (ref_pending),
    .ref_ptr (ref_ptr)
  );

  // armed keeps req_ready low for the first cycle out of reset so every
  // output reads 0 right after reset; a pending refresh blocks new requests.
  assign req_ready   = armed && (state == ST_IDLE) && !ref_pending;
  assign accept      = req_valid && req_ready;
  assign ref_advance = (state == ST_REF_WR);
  assign dbg_state   = state;

  // Strobes are gated by rst so no bank write or CM op can issue in a
  // cycle where reset is asserted, even if one was registered just before.
  assign bank_we  = we_q  & ~rst;
  assign bank_cme = cme_q & ~rst;

  // Main FSM: bank pin registers, latency counter and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_op    <= OP_READ;
      lat_cnt   <= '0;
      armed     <= 1'b0;
      we_q      <= 1'b0;
      cme_q     <= 1'b0;
      bank_addr <= '0;
      bank_d    <= '0;
      bank_cmin <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cm    <= 1'b0;
    end else begin
      armed <= 1'b1;
      we_q  <= 1'b0;
      cme_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ref_pending) begin
            state     <= ST_REF_RD;
            bank_addr <= ref_ptr;
          end else if (accept) begin
            state     <= ST_ISSUE;
            bank_addr <= req_addr;
            cur_op    <= (req_op == OP_RSVD) ? OP_READ : req_op;
            if (req_op == OP_WRITE) begin
              we_q   <= 1'b1;
              bank_d <= req_wdata;
            end
            if (req_op == OP_CM) begin
              cme_q     <= 1'b1;
              bank_cmin <= req_wdata;
            end
          end
        end
        ST_ISSUE: begin
          lat_cnt <= '0;
          state   <= (cur_op == OP_WRITE) ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_data  <= (cur_op == OP_CM) ? bank_cmout : bank_q;
            rsp_cm    <= (cur_op == OP_CM);
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_REF_RD: begin
          lat_cnt <= '0;
          state   <= ST_REF_WAIT;
        end
        ST_REF_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            bank_d <= bank_q;
            we_q   <= 1'b1;
            state  <= ST_REF_WR;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_REF_WR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DRAM_BANK_CTRL_PERF_EN
  // Saturating counters bumped on each ISSUE cycle (by opcode) and each
  // refresh write-back cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_cm_cnt  <= '0;
      perf_ref_cnt <= '0;
    end else begin
      if (state == ST_ISSUE && cur_op == OP_READ)  perf_rd_cnt  <= sat_inc(perf_rd_cnt);
      if (state == ST_ISSUE && cur_op == OP_WRITE) perf_wr_cnt  <= sat_inc(perf_wr_cnt);
      if (state == ST_ISSUE && cur_op == OP_CM)    perf_cm_cnt  <= sat_inc(perf_cm_cnt);
      if (state == ST_REF_WR)                      perf_ref_cnt <= sat_inc(perf_ref_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Directed bench for dram_bank_ctrl with a behavioural bank model
// (256 rows, one-cycle registered q, cmOut = row XOR cmIn).
module tb_dram_bank_ctrl;
  import dram_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 512;
  localparam int RL = 1;
  localparam int RI = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_cm;
  logic [AW-1:0] bank_addr;
  logic          bank_we;
  logic          bank_cme;
  logic [DW-1:0] bank_d;
  logic [DW-1:0] bank_cmin;
  logic [DW-1:0] bank_q;
  logic [DW-1:0] bank_cmout;
  logic [2:0]    dbg_state;
`ifdef DRAM_BANK_CTRL_PERF_EN
  logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_cm_cnt, perf_ref_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:255];

  dram_bank_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(RL), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cm(rsp_cm),
    .bank_addr(bank_addr), .bank_we(bank_we), .bank_cme(bank_cme),
    .bank_d(bank_d), .bank_cmin(bank_cmin), .bank_q(bank_q), .bank_cmout(bank_cmout),
    .dbg_state(dbg_state)
`ifdef DRAM_BANK_CTRL_PERF_EN
    ,
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
    .perf_cm_cnt(perf_cm_cnt), .perf_ref_cnt(perf_ref_cnt)
`endif
  );

  // ---------------- clock / bank model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_we) mem[bank_addr] <= bank_d;
    bank_q     <= mem[bank_addr];
    bank_cmout <= mem[bank_addr] ^ bank_cmin;
  end

  // Initial row contents: every byte of row i is i ^ 0x5A.
  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return {64{a ^ 8'h5A}};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a request, wait (bounded) for ready, return just after the
  // accepting edge (DUT is then in ISSUE).
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [DW-1:0] wd);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) tick();
    check("send_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_data"},  rsp_data,  '0);
    check({tag, "_rsp_cm"},    rsp_cm,    1'b0);
    check({tag, "_bank_addr"}, bank_addr, '0);
    check({tag, "_bank_we"},   bank_we,   1'b0);
    check({tag, "_bank_cme"},  bank_cme,  1'b0);
    check({tag, "_bank_d"},    bank_d,    '0);
    check({tag, "_bank_cmin"}, bank_cmin, '0);
    check({tag, "_state"},     dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  refs;
    int  k;
    int  bad;
    logic saw_acc;
    logic [DW-1:0] exp_d;

    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
    rst = 1'b1; req_valid = 1'b0; req_op = OP_READ; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", req_ready, 1'b1);

    // Back-to-back random reads with refresh interleaving (ptr 0 then 1).
    refs = 0;
    rsp_ready = 1'b1; req_op = OP_READ; req_valid = 1'b1;
    req_addr = 8'h40 + 8'($urandom_range(0, 15));
    for (int cyc = 0; cyc < 200 && refs < 2; cyc++) begin
      saw_acc = req_ready;
      if (req_ready) exp_q.push_back(pat(req_addr));
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
        else check("b2b_rd_data", rsp_data, exp_q.pop_front());
      end
      if (dbg_state == ST_REF_RD) begin
        check("ref_rd_addr", bank_addr, 8'(refs));
        check("ref_rd_we", bank_we, 1'b0);
      end
      if (dbg_state == ST_REF_WR) begin
        check("ref_wr_addr", bank_addr, 8'(refs));
        check("ref_wr_we", bank_we, 1'b1);
        check("ref_wr_data", bank_d, pat(8'(refs)));
        refs++;
      end
      tick();
      if (saw_acc) req_addr = 8'h40 + 8'($urandom_range(0, 15));
    end
    req_valid = 1'b0;
    check("ref_pairs", refs, 2);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
        else check("b2b_rd_data", rsp_data, exp_q.pop_front());
      end
      tick();
    end
    check("exp_q_empty", exp_q.size(), 0);
    rsp_ready = 1'b0;

    // WRITE 0x05 then READ 0x05.
    send(OP_WRITE, 8'h05, {64{8'hA5}});
    check("wr_state", dbg_state, ST_ISSUE);
    check("wr_we", bank_we, 1'b1);
    check("wr_addr", bank_addr, 8'h05);
    check("wr_d", bank_d, {64{8'hA5}});
    check("wr_cme", bank_cme, 1'b0);
    tick();
    check("wr_we_pulse", bank_we, 1'b0);
    check("wr_back_idle", dbg_state, ST_IDLE);
    check("wr_no_rsp", rsp_valid, 1'b0);
`ifdef DRAM_BANK_CTRL_PERF_EN
    check("perf_wr", perf_wr_cnt, 32'd1);
`endif
    send(OP_READ, 8'h05, '0);
    check("rd_we", bank_we, 1'b0);
    check("rd_cme", bank_cme, 1'b0);
    check("rd_addr", bank_addr, 8'h05);
    check("rd_d_hold", bank_d, {64{8'hA5}});
    tick();
    check("rd_not_yet", rsp_valid, 1'b0);
    tick();
    check("rd_valid", rsp_valid, 1'b1);
    check("rd_data", rsp_data, {64{8'hA5}});
    check("rd_cm", rsp_cm, 1'b0);
    rsp_ready = 1'b1;
    tick();
    check("rd_done", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // CM at 0x10: row byte 0x4A ^ operand 0x3C = 0x76.
    send(OP_CM, 8'h10, {64{8'h3C}});
    check("cm_cme", bank_cme, 1'b1);
    check("cm_we", bank_we, 1'b0);
    check("cm_cmin", bank_cmin, {64{8'h3C}});
    check("cm_addr", bank_addr, 8'h10);
    tick();
    check("cm_cme_pulse", bank_cme, 1'b0);
    check("cm_cmin_hold", bank_cmin, {64{8'h3C}});
    tick();
    check("cm_valid", rsp_valid, 1'b1);
    check("cm_data", rsp_data, {64{8'h76}});
    check("cm_flag", rsp_cm, 1'b1);
`ifdef DRAM_BANK_CTRL_PERF_EN
    check("perf_cm", perf_cm_cnt, 32'd1);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reserved opcode behaves as READ of 0x22 (byte 0x78).
    send(OP_RSVD, 8'h22, {64{8'hFF}});
    check("rsvd_we", bank_we, 1'b0);
    check("rsvd_cme", bank_cme, 1'b0);
    tick(); tick();
    check("rsvd_data", rsp_data, {64{8'h78}});
    check("rsvd_cm", rsp_cm, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-pressure: align just after a refresh so none intervenes.
    for (int i = 0; i < 100 && dbg_state != ST_REF_WR; i++) tick();
    check("sync_ref", dbg_state, ST_REF_WR);
    send(OP_READ, 8'h22, '0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_data", rsp_data, {64{8'h78}});
      check("bp_ready", req_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    req_op = OP_READ; req_addr = 8'h05; req_valid = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_ready", req_ready, 1'b1);
    tick();
    check("bp_next_accept", dbg_state, ST_ISSUE);
    req_valid = 1'b0;
    tick(); tick();
    check("bp_next_data", rsp_data, {64{8'hA5}});
    tick();
    rsp_ready = 1'b0;

    // Reset during ISSUE of a write: strobe must be gated immediately.
    send(OP_WRITE, 8'h33, {64{8'hFF}});
    check("rstw_we_before", bank_we, 1'b1);
    rst = 1'b1;
    #1;
    check("rstw_we_gated", bank_we, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Reset during WAIT of a read: response dropped, outputs cleared.
    send(OP_READ, 8'h22, '0);
    tick();
    check("rstr_in_wait", dbg_state, ST_WAIT);
    rst = 1'b1;
    tick();
    check_all_zero("rst_wait");
    rst = 1'b0;

    // Sweep 257 refresh write-backs: pointer restarts at 0, wraps FF->00.
    k = 0; bad = 0;
    for (int cyc = 0; cyc < 10000 && k < 257; cyc++) begin
      if (dbg_state == ST_REF_WR) begin
        exp_d = (k == 5) ? {64{8'hA5}} : pat(8'(k));
        if (k == 0)   check("ptr_after_rst", bank_addr, 8'h00);
        if (k == 255) check("ptr_ff", bank_addr, 8'hFF);
        if (k == 256) check("ptr_wrap", bank_addr, 8'h00);
        if (k < 256 && bank_addr !== 8'(k)) bad++;
        if (k < 256 && bank_d !== exp_d) bad++;
        if (rsp_valid) bad++;
        k++;
        tick();
`ifdef DRAM_BANK_CTRL_PERF_EN
        if (k == 256) check("perf_ref", perf_ref_cnt, 32'd256);
`endif
      end else begin
        if (rsp_valid) bad++;
        tick();
      end
    end
    check("sweep_count", k, 257);
    check("sweep_bad", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
